// File: rtl/rx_iq_interleaver.sv
// Per-channel IQ FIFOs drained as ordered sets (chan 0 .. nr_lat-1) onto one valid/ready stream.
// Optional RX_IQ_INTERLEAVER_OVF_COUNT_EN adds 8-bit saturating per-channel drop counters (ovf_cnt).
module rx_iq_interleaver #(
    parameter int NR    = 6,
    parameter int IQW   = 24,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NR*2*IQW-1:0]   rx_tdata,
    input  logic [NR-1:0]         rx_tvalid,
    input  logic [3:0]            nr_active,
    output logic [2*IQW-1:0]      out_tdata,
    output logic [3:0]            out_tchan,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready,
    input  logic                  ovf_clr,
    output logic [NR-1:0]         ovf
`ifdef RX_IQ_INTERLEAVER_OVF_COUNT_EN
    ,
    output logic [NR*8-1:0]       ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = 2 * IQW;
    localparam logic [3:0]  NR4   = 4'(NR);
    localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);
    localparam logic [AW:0] PONE  = (AW+1)'(1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state_q, state_d;
    logic [3:0]           nr_lat_q, nr_lat_d, nr_eff, nxt;
    logic [W-1:0]         data_q, data_d, nxt_head;
    logic [3:0]           chan_q, chan_d;
    logic                 vld_q, vld_d, last_q, last_d;
    logic                 accept, all_ne;
    logic [NR-1:0]        empty, active, pop, drop;
    logic [NR-1:0][W-1:0] head;

    assign accept     = vld_q && out_tready;
    assign out_tdata  = data_q;
    assign out_tchan  = chan_q;
    assign out_tvalid = vld_q;
    assign out_tlast  = last_q;

    for (genvar i = 0; i < NR; i++) begin : g_ch
        logic [W-1:0] mem_q [DEPTH];
        logic [AW:0]  wptr_q, rptr_q, fill;
        logic         full, push;

        assign fill      = wptr_q - rptr_q;
        assign full      = (fill == FULLC);
        assign empty[i]  = (fill == '0);
        assign active[i] = (4'(i) < nr_lat_q);
        assign pop[i]    = accept && (chan_q == 4'(i));
        // A full FIFO still takes a sample when its head leaves this same cycle.
        assign push      = active[i] && rx_tvalid[i] && (!full || pop[i]);
        assign drop[i]   = active[i] && rx_tvalid[i] && full && !pop[i];
        assign head[i]   = mem_q[rptr_q[AW-1:0]];

        always_ff @(posedge clk) begin
            if (rst || !active[i]) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push)   wptr_q <= wptr_q + PONE;
                if (pop[i]) rptr_q <= rptr_q + PONE;
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem_q[wptr_q[AW-1:0]] <= rx_tdata[i*W +: W];
        end

`ifdef RX_IQ_INTERLEAVER_OVF_COUNT_EN
        logic [7:0] cnt_q;
        always_ff @(posedge clk) begin
            if (rst)                            cnt_q <= 8'd0;
            else if (ovf_clr)                   cnt_q <= {7'd0, drop[i]};
            else if (drop[i] && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end
        assign ovf_cnt[i*8 +: 8] = cnt_q;
        assign ovf[i]            = |cnt_q;
`else
        logic ovf_q;
        always_ff @(posedge clk) begin
            if (rst)          ovf_q <= 1'b0;
            else if (drop[i]) ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
        assign ovf[i] = ovf_q;
`endif
    end

    always_comb begin
        nr_eff = nr_active;
        if (nr_active == 4'd0)     nr_eff = 4'd1;
        else if (nr_active > NR4)  nr_eff = NR4;
    end

    // In IDLE the set size is taken straight from nr_eff so the start test and the latched size agree.
    always_comb begin
        all_ne = 1'b1;
        for (int i = 0; i < NR; i++)
            if ((4'(i) < nr_eff) && empty[i]) all_ne = 1'b0;
    end

    always_comb begin
        nxt      = chan_q + 4'd1;
        nxt_head = head[0];
        for (int i = 0; i < NR; i++)
            if (4'(i) == nxt) nxt_head = head[i];
    end

    always_comb begin
        state_d  = state_q;
        nr_lat_d = nr_lat_q;
        data_d   = data_q;
        chan_d   = chan_q;
        vld_d    = vld_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                nr_lat_d = nr_eff;
                if (all_ne) begin
                    data_d  = head[0];
                    chan_d  = 4'd0;
                    vld_d   = 1'b1;
                    last_d  = (nr_eff == 4'd1);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (accept) begin
                    if (last_q) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        data_d = nxt_head;
                        chan_d = nxt;
                        last_d = (nxt == nr_lat_q - 4'd1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            nr_lat_q <= 4'd1;
            data_q   <= '0;
            chan_q   <= 4'd0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nr_lat_q <= nr_lat_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_rx_iq_interleaver.sv
// Directed bench: stimulus queues expected beats, a negedge monitor pops and compares accepted beats.
module tb_rx_iq_interleaver;

    localparam int NR = 6, IQW = 24, DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR*2*IQW-1:0] rx_tdata;
    logic [NR-1:0]       rx_tvalid;
    logic [3:0]          nr_active;
    logic [2*IQW-1:0]    out_tdata;
    logic [3:0]          out_tchan;
    logic                out_tvalid, out_tlast, out_tready, ovf_clr;
    logic [NR-1:0]       ovf;
`ifdef RX_IQ_INTERLEAVER_OVF_COUNT_EN
    logic [NR*8-1:0]     ovf_cnt;
`endif

    rx_iq_interleaver #(.NR(NR), .IQW(IQW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
        .nr_active(nr_active), .out_tdata(out_tdata), .out_tchan(out_tchan),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .ovf_clr(ovf_clr), .ovf(ovf)
`ifdef RX_IQ_INTERLEAVER_OVF_COUNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [47:0] d; logic [3:0] c; logic l; } beat_t;
    beat_t sb[$];
    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [47:0] dat(input int ch, input int tag);
        logic [23:0] i_s, q_s;
        i_s = 24'h100000 + 24'(tag * 256) + 24'(ch);
        q_s = 24'h200000 + 24'(tag * 256) + 24'(ch);
        return {i_s, q_s};
    endfunction

    task automatic cycle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; the sample is taken on the next edge and the task returns at posedge+1.
    task automatic push(input logic [NR-1:0] mask, input int tag);
        for (int ch = 0; ch < NR; ch++) rx_tdata[ch*48 +: 48] = dat(ch, tag);
        rx_tvalid = mask;
        @(posedge clk); #1;
        rx_tvalid = '0;
    endtask

    task automatic exp_set(input int n, input int tag);
        for (int ch = 0; ch < n; ch++) sb.push_back('{d: dat(ch, tag), c: 4'(ch), l: (ch == n - 1)});
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 200 && sb.size() != 0; k++) cycle(1);
        check({nm, "_drained"}, 64'(sb.size()), 64'd0);
        cycle(2);
        check({nm, "_idle"}, 64'(out_tvalid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_tvalid && out_tready) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_beat: got chan %0d data %h expected none", out_tchan, out_tdata);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat", {out_tdata, out_tchan, out_tlast}, {e.d, e.c, e.l});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int exp_c[10] = '{0, 1, 2, 3, -1, 0, 1, 2, 3, -1};

    initial begin
        rst = 1'b1; rx_tdata = '0; rx_tvalid = '0; nr_active = 4'd4;
        out_tready = 1'b1; ovf_clr = 1'b0;
        cycle(3);
        check("rst_outs", {out_tdata, out_tchan, out_tvalid, out_tlast}, 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        cycle(2);

        // 1: two back-to-back 4-channel sets, one idle cycle between them
        push(6'h0F, 1); exp_set(4, 1);
        push(6'h0F, 2); exp_set(4, 2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (exp_c[k] < 0) check("t1_gap", 64'(out_tvalid), 64'd0);
            else check("t1_seq", {out_tvalid, out_tchan}, {1'b1, 4'(exp_c[k])});
        end
        @(posedge clk); #1;
        drain("t1");

        // 2: stall on beat 1 for five cycles
        push(6'h0F, 20); exp_set(4, 20);
        cycle(2);
        out_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_hold", {out_tvalid, out_tchan, out_tdata}, {1'b1, 4'd1, dat(1, 20)});
        end
        @(posedge clk); #1;
        out_tready = 1'b1;
        drain("t2");

        // 3: fifth sample into full channel 2 is dropped
        out_tready = 1'b0;
        for (int t = 0; t < 4; t++) begin push(6'h0F, 10 + t); exp_set(4, 10 + t); end
        push(6'h04, 99);
        check("t3_ovf", 64'(ovf), 64'h04);
        out_tready = 1'b1;
        drain("t3");
        check("t3_sticky", 64'(ovf), 64'h04);
        ovf_clr = 1'b1; cycle(1); ovf_clr = 1'b0;
        check("t3_clr", 64'(ovf), 64'd0);

        // 4: nr_active clamping and mid-set change
        nr_active = 4'd0; cycle(2);
        push(6'h01, 30); exp_set(1, 30);
        cycle(1);
        check("t4_one", {out_tvalid, out_tlast, out_tchan}, {1'b1, 1'b1, 4'd0});
        cycle(1);
        check("t4_one_end", 64'(out_tvalid), 64'd0);
        drain("t4a");
        nr_active = 4'd15; cycle(2);
        push(6'h3F, 31); exp_set(6, 31);
        drain("t4b");
        nr_active = 4'd2; cycle(2);
        push(6'h3F, 32); exp_set(2, 32);
        cycle(1);
        nr_active = 4'd5;
        drain("t4c");

        // 5: reset during beat 2 of a 6-beat set
        nr_active = 4'd15; cycle(2);
        out_tready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            push(6'h3F, 40 + t);
            if (t < 4) exp_set(6, 40 + t);
        end
        check("t5_ovf", 64'(ovf), 64'h3F);
        out_tready = 1'b1;
        for (int k = 0; k < 20 && !(out_tvalid && out_tchan == 4'd2); k++) cycle(1);
        check("t5_reach", {out_tvalid, out_tchan}, {1'b1, 4'd2});
        rst = 1'b1; cycle(1);
        check("t5_rst", {out_tvalid, out_tchan, out_tlast}, 64'd0);
        check("t5_rst_ovf", 64'(ovf), 64'd0);
        sb.delete();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin cycle(1); check("t5_quiet", 64'(out_tvalid), 64'd0); end
        push(6'h3F, 50); exp_set(6, 50);
        cycle(1);
        check("t5_fresh", {out_tvalid, out_tchan}, {1'b1, 4'd0});
        drain("t5");

`ifdef RX_IQ_INTERLEAVER_OVF_COUNT_EN
        // 6: counter saturation and clear-with-drop
        nr_active = 4'd1; cycle(2);
        out_tready = 1'b0;
        for (int t = 0; t < 304; t++) begin
            push(6'h01, (t < 4) ? 60 + t : 70);
            if (t < 4) exp_set(1, 60 + t);
        end
        check("t6_sat", {ovf[0], ovf_cnt[7:0]}, {1'b1, 8'd255});
        ovf_clr = 1'b1;
        push(6'h01, 71);
        ovf_clr = 1'b0;
        check("t6_clr_drop", 64'(ovf_cnt[7:0]), 64'd1);
        ovf_clr = 1'b1; cycle(1); ovf_clr = 1'b0;
        check("t6_clr", {ovf, ovf_cnt}, 64'd0);
        out_tready = 1'b1;
        drain("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_iq_interleaver.md
Name: rx_iq_interleaver

Overview:
- Collects IQ samples from a parametrised number of DDC receiver channels, buffers each channel in a small FIFO, and emits them as one ordered set per sample instant: channel 0 first, channel N-1 last.
- Output is a valid/ready stream feeding the Ethernet RX packetiser inside the core.
- Generalises the receiver count to NR channels, with a runtime-selectable active-channel count and per-channel overflow reporting.

Parameters:
- NR, 6, number of physical receiver channels (1..12)
- IQW, 24, bit width of each I or Q sample
- DEPTH, 4, per-channel FIFO depth in samples; power of two, at least 2

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_tdata  input  NR*2*IQW  channel i occupies [i*2*IQW +: 2*IQW], with I in the upper IQW bits and Q in the lower IQW bits
- rx_tvalid  input  NR  per-channel sample strobe, one sample per high cycle
- nr_active  input  4  number of active channels requested by host
- out_tdata  output  2*IQW  current IQ word
- out_tchan  output  4  channel index of current word
- out_tvalid  output  1  word valid
- out_tlast  output  1  last word of set
- out_tready  input  1  downstream accept
- ovf_clr  input  1  single-cycle clear of overflow flags
- ovf  output  NR  sticky per-channel overflow flags

Behaviour:
- Reset and interface rules:
  - Clock is clk; reset is rst, synchronous and active-high. All state updates occur on rising clk.
  - Reset clears all outputs to 0, flushes all FIFOs, clears ovf, sets state IDLE and nr_lat=1.
  - A reset asserted mid-set abandons the set; no partial word is emitted after reset.
- Active channel count:
  - Effective count nr_eff = 1 if nr_active==0, NR if nr_active>NR, otherwise nr_active.
  - nr_lat captures nr_eff only in IDLE. Changing nr_active mid-set has no effect until the next set.
  - Channels i >= nr_lat ignore rx_tvalid and are held flushed. They never set ovf.
- FIFO write:
  - Active channel i pushes rx_tdata slice when rx_tvalid[i]=1 and its FIFO is not full.
  - A push to a full FIFO is accepted if that FIFO is popped in the same cycle.
  - Otherwise the push is dropped and ovf[i] is set.
- Overflow flags:
  - ovf_clr clears all flags.
  - If a new overflow coincides with ovf_clr, the flag for that channel ends set.
- State machine:
  - IDLE: when every channel 0..nr_lat-1 is non-empty, load channel 0's head into the output registers. This sets out_tvalid=1, out_tchan=0 and out_tlast=(nr_lat==1), then moves to EMIT.
  - EMIT, beat not last: when out_tvalid && out_tready, pop the current channel and load the next channel's head, with out_tchan incremented and out_tlast=(next==nr_lat-1).
  - EMIT, last beat: when out_tvalid && out_tready, pop the current channel, drive out_tvalid=0 and out_tlast=0, and return to IDLE.
  - When out_tready=0, out_tdata, out_tchan and out_tlast hold stable and out_tvalid stays 1.
- Latency and throughput:
  - First beat is valid 1 cycle after the all-non-empty condition is seen.
  - With ready held high, a set takes nr_lat consecutive cycles.
  - There is exactly one idle cycle between sets.
- FIFOs:
  - Pointers are clog2(DEPTH)+1 bits and wrap naturally.
  - Full means count==DEPTH; empty means count==0.

Optional Feature:
- Macro: RX_IQ_INTERLEAVER_OVF_COUNT_EN
- Defined: adds output ovf_cnt of width NR*8, holding an 8-bit saturating counter per channel at [i*8 +: 8].
  - The counter increments on each dropped sample and saturates at 255.
  - ovf_clr zeroes all counters; a drop coinciding with ovf_clr leaves a count of 1.
  - ovf[i] = (ovf_cnt[i]!=0).
- Undefined: port is absent; ovf behaves as sticky flags only.

Test Plan:
1. Set NR=6, nr_active=4, and pulse rx_tvalid[3:0] with channel i's data = {I=24'h10000i, Q=24'h20000i}, out_tready=1. Required: 4 consecutive beats with out_tchan 0,1,2,3, matching data, out_tlast only on chan 3, then one idle cycle.
2. Hold out_tready=0 after the first beat for 5 cycles. Required: out_tdata, out_tchan and out_tvalid stable for those 5 cycles; the set completes with no loss once ready returns.
3. With out_tready=0, push 5 samples into channel 2 (DEPTH=4). Required: ovf[2]=1 with the 5th sample dropped; later sets carry samples 1-4 in order; an ovf_clr pulse returns ovf to 0.
4. Apply nr_active=0 and then nr_active=15. Required: sets of 1 and 6 beats respectively; change nr_active from 2 to 5 mid-set and the current set still ends at chan 1.
5. Assert rst during beat 2 of a 6-beat set. Required: out_tvalid=0 the next cycle, all FIFOs empty, ovf=0; fresh pushes produce a complete set starting at chan 0.
6. With the macro defined, drop 300 samples on channel 0. Required: ovf_cnt[7:0]=255; ovf_clr coinciding with a drop leaves a count of 1.
